// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the EX-stage ALU control decoder and its iterative
// multiply/divide engine.
//   - ALUOp encodings driven by the main control unit
//   - R-format Funct codes recognised by the decoder
//   - 4-bit ALU operation codes produced for the ALU
//   - engine FSM states and engine operation selector
//   - helpers classifying Funct codes that touch HI/LO
package alu_ctrl_pkg;

  localparam logic [1:0] ALUOP_ADD     = 2'b00;
  localparam logic [1:0] ALUOP_SUB     = 2'b01;
  localparam logic [1:0] ALUOP_RFORMAT = 2'b10;
  localparam logic [1:0] ALUOP_AND     = 2'b11;

  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_JR    = 6'd8;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_NOR   = 6'd39;
  localparam logic [5:0] F_SLT   = 6'd42;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2
  } state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  // Funct codes that read or write HI/LO (and therefore may stall).
  function automatic logic is_hilo_funct(input logic [5:0] f);
    return f inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                     F_MULT, F_MULTU, F_DIV, F_DIVU};
  endfunction

  // Funct codes that start the multiply/divide engine.
  function automatic logic is_muldiv_funct(input logic [5:0] f);
    return f inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide engine, one iteration per clock.
//   clk_i, reset_i : clock, synchronous active-high reset
//   start_i        : begin an operation (only honoured in IDLE)
//   op_i           : OP_MUL or OP_DIV
//   signed_i       : operands are two's complement
//   a_i, b_i       : multiplicand/dividend, multiplier/divisor
//   busy_o         : engine is not IDLE
//   done_o         : FIX cycle; hi_o/lo_o hold the final result this cycle
//   hi_o, lo_o     : product {hi,lo}, or remainder (hi) / quotient (lo)
// Operands are reduced to magnitudes at start, the unsigned core runs WIDTH
// iterations, and the sign is restored in the FIX cycle.
module muldiv_iter
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  op_e              op_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;

  // acc_q: upper product half / partial remainder.
  // qr_q : multiplier shifting out / quotient shifting in.
  // opd_q: multiplicand / divisor magnitude.
  op_e              op_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] qr_q, qr_d;
  logic [WIDTH-1:0] opd_q;
  logic             neg_lo_q;  // negate product (MUL) or quotient (DIV)
  logic             neg_hi_q;  // negate remainder (DIV)

  logic             a_neg, b_neg, div_zero;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg    = signed_i & a_i[WIDTH-1];
  assign b_neg    = signed_i & b_i[WIDTH-1];
  assign a_mag    = a_neg ? -a_i : a_i;
  assign b_mag    = b_neg ? -b_i : b_i;
  assign div_zero = (op_i == OP_DIV) && (b_i == '0);

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == FIX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= BUSY;
            cnt_q   <= '0;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= FIX;
        end
        FIX:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: datapath registers are not reset; they are always loaded at start
  // and only observed through done_o, so a reset would add nothing.
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && start_i) begin
      op_q  <= op_i;
      acc_q <= '0;
      // Divide by zero runs the raw dividend through the unsigned core with
      // a zero divisor: every trial subtraction succeeds, so the quotient
      // fills with ones and the remainder ends up equal to the dividend.
      qr_q     <= div_zero ? a_i : a_mag;
      opd_q    <= b_mag;
      neg_lo_q <= !div_zero && (a_neg ^ b_neg);
      neg_hi_q <= !div_zero && a_neg;
    end else if (state_q == BUSY) begin
      acc_q <= acc_d;
      qr_q  <= qr_d;
    end
  end

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  // NOTE: every variable gets a default at the top of always_comb so no
  // path can infer a latch.
  always_comb begin
    acc_d   = acc_q;
    qr_d    = qr_q;
    // Shift-add: add multiplicand when the multiplier LSB is set, then
    // shift {carry, acc, multiplier} right by one.
    mul_sum = {1'b0, acc_q} + ({(WIDTH+1){qr_q[0]}} & {1'b0, opd_q});
    // Restoring divide: bring in the next dividend bit, trial-subtract.
    shifted = {acc_q, qr_q[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, opd_q};
    if (op_q == OP_MUL) begin
      acc_d = mul_sum[WIDTH:1];
      qr_d  = {mul_sum[0], qr_q[WIDTH-1:1]};
    end else if (!trial[WIDTH+1]) begin
      acc_d = trial[WIDTH-1:0];
      qr_d  = {qr_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = shifted[WIDTH-1:0];
      qr_d  = {qr_q[WIDTH-2:0], 1'b0};
    end
  end

  logic [2*WIDTH-1:0] product, prod_fix;

  // Sign restoration presented during FIX.
  always_comb begin
    product  = {acc_q, qr_q};
    prod_fix = neg_lo_q ? -product : product;
    if (op_q == OP_MUL) begin
      hi_o = prod_fix[2*WIDTH-1:WIDTH];
      lo_o = prod_fix[WIDTH-1:0];
    end else begin
      hi_o = neg_hi_q ? -acc_q : acc_q;
      lo_o = neg_lo_q ? -qr_q : qr_q;
    end
  end

endmodule

// File: rtl/alu_control_muldiv.sv
// EX-stage ALU control with HI/LO multiply/divide support.
//   clk, reset       : clock, synchronous active-high reset
//   issue            : a valid instruction is in EX this cycle
//   ALUOp, Funct     : main-control op class and R-format function field
//   a, b             : rs / rt operands
//   alucontrol       : 4-bit ALU operation code
//   jr, sign, illegal: decode flags
//   use_hilo         : instruction is MFHI/MFLO; EX mux selects hilo_rd
//   hilo_rd          : HI for MFHI, LO otherwise
//   stall            : hold EX and upstream stages
//   busy             : multiply/divide engine not idle
//   hi, lo           : architectural HI/LO registers
module alu_control_muldiv
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       alucontrol,
  output logic             jr,
  output logic             sign,
  output logic             illegal,
  output logic             use_hilo,
  output logic [WIDTH-1:0] hilo_rd,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic             rformat, hilo_class, accept, start, is_signed;
  op_e              op;
  logic             eng_busy, eng_done;
  logic [WIDTH-1:0] eng_hi, eng_lo;
  logic [WIDTH-1:0] hi_q, lo_q;

  // ---------------- decode ----------------
  always_comb begin
    alucontrol = ALU_ADD;
    illegal    = 1'b0;
    case (ALUOp)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_AND: alucontrol = ALU_AND;
      default: begin
        case (Funct)
          F_ADD: alucontrol = ALU_ADD;
          F_SUB: alucontrol = ALU_SUB;
          F_AND: alucontrol = ALU_AND;
          F_OR:  alucontrol = ALU_OR;
          F_NOR: alucontrol = ALU_NOR;
          F_SLT: alucontrol = ALU_SLT;
          F_SLL: alucontrol = ALU_SLL;
          // Non-ALU R-format instructions keep the adder selected.
          F_JR, F_MFHI, F_MTHI, F_MFLO, F_MTLO,
          F_MULT, F_MULTU, F_DIV, F_DIVU: alucontrol = ALU_ADD;
          default: illegal = 1'b1;
        endcase
      end
    endcase
  end

  assign rformat    = (ALUOp == ALUOP_RFORMAT);
  assign jr         = rformat && (Funct == F_JR);
  assign sign       = (ALUOp != ALUOP_AND);
  assign use_hilo   = rformat && (Funct == F_MFHI || Funct == F_MFLO);
  assign hilo_rd    = (Funct == F_MFHI) ? hi_q : lo_q;
  assign hilo_class = rformat && is_hilo_funct(Funct);

  // ---------------- stall / accept ----------------
  // Any HI/LO instruction waits while the engine runs (FIX included), so an
  // accepted one always finds the engine IDLE and HI/LO up to date.
  assign stall     = issue && hilo_class && eng_busy;
  assign accept    = issue && hilo_class && !stall;
  assign start     = accept && is_muldiv_funct(Funct);
  assign op        = (Funct == F_DIV || Funct == F_DIVU) ? OP_DIV : OP_MUL;
  assign is_signed = (Funct == F_MULT || Funct == F_DIV);
  assign busy      = eng_busy;

  muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk_i    (clk),
    .reset_i  (reset),
    .start_i  (start),
    .op_i     (op),
    .signed_i (is_signed),
    .a_i      (a),
    .b_i      (b),
    .busy_o   (eng_busy),
    .done_o   (eng_done),
    .hi_o     (eng_hi),
    .lo_o     (eng_lo)
  );

  // ---------------- HI/LO ----------------
  // Engine completion and MTHI/MTLO never coincide: MT* is accepted only
  // when the engine is IDLE, completion happens only in FIX.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (eng_done) begin
      hi_q <= eng_hi;
      lo_q <= eng_lo;
    end else if (accept) begin
      if (Funct == F_MTHI) hi_q <= a;
      if (Funct == F_MTLO) lo_q <= a;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_alu_control_muldiv.sv
// Scoreboard bench: the stimulus process updates an architectural HI/LO
// model on acceptance and queues expected results; a monitor process
// compares them when the engine finishes or an MFHI/MFLO is accepted.
module tb_alu_control_muldiv;
  import alu_ctrl_pkg::*;

  localparam int W  = 32;
  localparam int W2 = 2 * W;

  logic         clk = 1'b0;
  logic         reset, issue;
  logic [1:0]   ALUOp;
  logic [5:0]   Funct;
  logic [W-1:0] a, b;
  logic [3:0]   alucontrol;
  logic         jr, sign, illegal, use_hilo, stall, busy;
  logic [W-1:0] hilo_rd, hi, lo;

  alu_control_muldiv #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .issue      (issue),
    .ALUOp      (ALUOp),
    .Funct      (Funct),
    .a          (a),
    .b          (b),
    .alucontrol (alucontrol),
    .jr         (jr),
    .sign       (sign),
    .illegal    (illegal),
    .use_hilo   (use_hilo),
    .hilo_rd    (hilo_rd),
    .stall      (stall),
    .busy       (busy),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [W2-1:0] res_q[$];  // expected {hi,lo} per multiply/divide
  logic [W-1:0]  mf_q[$];   // expected hilo_rd per MFHI/MFLO
  logic [W-1:0]  hi_m = '0;
  logic [W-1:0]  lo_m = '0;

  task automatic check(input string name, input logic [W2-1:0] act,
                       input logic [W2-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference arithmetic at 2W bits: no overflow even for MIN / -1.
  function automatic logic [W2-1:0] model_muldiv(input logic [5:0] f,
                                                 input logic [W-1:0] x,
                                                 input logic [W-1:0] y);
    logic signed [W2-1:0] sx, sy;
    logic [W2-1:0]        ux, uy, q, r;
    sx = $signed(x);
    sy = $signed(y);
    ux = {{W{1'b0}}, x};
    uy = {{W{1'b0}}, y};
    case (f)
      F_MULT:  return sx * sy;
      F_MULTU: return ux * uy;
      default: begin
        if (y == '0) return {x, {W{1'b1}}};
        if (f == F_DIV) begin
          q = sx / sy;
          r = sx % sy;
        end else begin
          q = ux / uy;
          r = ux % uy;
        end
        return {r[W-1:0], q[W-1:0]};
      end
    endcase
  endfunction

  task automatic model_accept(input logic [5:0] f, input logic [W-1:0] x,
                              input logic [W-1:0] y);
    logic [W2-1:0] r;
    case (f)
      F_MTHI: hi_m = x;
      F_MTLO: lo_m = x;
      F_MFHI: mf_q.push_back(hi_m);
      F_MFLO: mf_q.push_back(lo_m);
      default: begin
        r = model_muldiv(f, x, y);
        {hi_m, lo_m} = r;
        res_q.push_back(r);
      end
    endcase
  endtask

  // Issue an R-format HI/LO instruction, hold it until accepted, and report
  // how many cycles it was stalled. Called at least 1 time unit after posedge.
  task automatic do_op(input logic [5:0] f, input logic [W-1:0] x,
                       input logic [W-1:0] y, output int stalls);
    bit ok;
    ok     = 1'b0;
    stalls = 0;
    ALUOp  = ALUOP_RFORMAT;
    Funct  = f;
    a      = x;
    b      = y;
    issue  = 1'b1;
    #1;
    for (int i = 0; i < 200; i++) begin
      if (!stall) begin
        ok = 1'b1;
        break;
      end
      stalls++;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: funct %0d still stalled after 200 cycles", f);
    end else begin
      model_accept(f, x, y);
    end
    @(posedge clk);
    #1;
    issue = 1'b0;
  endtask

  task automatic dec_chk(input logic [1:0] aop, input logic [5:0] f,
                         input logic [3:0] ctl, input logic e_jr,
                         input logic e_sign, input logic e_ill,
                         input logic e_uh);
    ALUOp = aop;
    Funct = f;
    #1;
    check($sformatf("alucontrol op%0d f%0d", aop, f), W2'(alucontrol), W2'(ctl));
    check($sformatf("jr op%0d f%0d", aop, f), W2'(jr), W2'(e_jr));
    check($sformatf("sign op%0d f%0d", aop, f), W2'(sign), W2'(e_sign));
    check($sformatf("illegal op%0d f%0d", aop, f), W2'(illegal), W2'(e_ill));
    check($sformatf("use_hilo op%0d f%0d", aop, f), W2'(use_hilo), W2'(e_uh));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return W'($urandom_range(0, 9));
      4:       return -W'($urandom_range(1, 9));
      default: return W'($urandom());
    endcase
  endfunction

  // ---------------- monitor ----------------
  logic          prev_busy = 1'b0;
  int            busy_cnt  = 0;
  logic [W2-1:0] exp_res;
  logic [W-1:0]  exp_rd;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_busy = 1'b0;
        busy_cnt  = 0;
      end else begin
        if (issue && use_hilo && !stall) begin
          if (mf_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL mf_unexpected: hilo_rd=%0h with no read queued", hilo_rd);
          end else begin
            exp_rd = mf_q.pop_front();
            check("hilo_rd", W2'(hilo_rd), W2'(exp_rd));
          end
        end
        if (busy) begin
          busy_cnt++;
        end else if (prev_busy) begin
          check("busy_cycles", W2'(busy_cnt), W2'(W + 1));
          if (res_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL res_unexpected: hi=%0h lo=%0h with no result queued", hi, lo);
          end else begin
            exp_res = res_q.pop_front();
            check("hi_lo", {hi, lo}, exp_res);
          end
          busy_cnt = 0;
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int st;
    reset = 1'b1;
    issue = 1'b0;
    ALUOp = ALUOP_ADD;
    Funct = F_ADD;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", W2'(busy), '0);
    check("reset hi_lo", {hi, lo}, '0);
    reset = 1'b0;

    // Decode sweep (issue=0).
    dec_chk(ALUOP_ADD, F_JR, 4'b0010, 0, 1, 0, 0);
    dec_chk(ALUOP_SUB, F_ADD, 4'b0110, 0, 1, 0, 0);
    dec_chk(ALUOP_AND, F_MFHI, 4'b0000, 0, 0, 0, 0);
    dec_chk(ALUOP_RFORMAT, 6'd32, 4'b0010, 0, 1, 0, 0);
    dec_chk(ALUOP_RFORMAT, 6'd34, 4'b0110, 0, 1, 0, 0);
    dec_chk(ALUOP_RFORMAT, 6'd36, 4'b0000, 0, 1, 0, 0);
    dec_chk(ALUOP_RFORMAT, 6'd37, 4'b0001, 0, 1, 0, 0);
    dec_chk(ALUOP_RFORMAT, 6'd39, 4'b1100, 0, 1, 0, 0);
    dec_chk(ALUOP_RFORMAT, 6'd42, 4'b0111, 0, 1, 0, 0);
    dec_chk(ALUOP_RFORMAT, 6'd0, 4'b0011, 0, 1, 0, 0);
    dec_chk(ALUOP_RFORMAT, 6'd8, 4'b0010, 1, 1, 0, 0);
    dec_chk(ALUOP_RFORMAT, 6'd5, 4'b0010, 0, 1, 1, 0);
    dec_chk(ALUOP_RFORMAT, 6'd63, 4'b0010, 0, 1, 1, 0);
    dec_chk(ALUOP_RFORMAT, 6'd16, 4'b0010, 0, 1, 0, 1);
    dec_chk(ALUOP_RFORMAT, 6'd18, 4'b0010, 0, 1, 0, 1);
    dec_chk(ALUOP_RFORMAT, 6'd17, 4'b0010, 0, 1, 0, 0);
    dec_chk(ALUOP_RFORMAT, 6'd19, 4'b0010, 0, 1, 0, 0);
    dec_chk(ALUOP_RFORMAT, 6'd24, 4'b0010, 0, 1, 0, 0);
    dec_chk(ALUOP_RFORMAT, 6'd27, 4'b0010, 0, 1, 0, 0);
    check("idle stall", W2'(stall), '0);
    @(posedge clk);
    #1;

    // Multiply and divide corner cases.
    do_op(F_MULT, 32'hFFFF_FFFF, 32'h0000_0002, st);
    do_op(F_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, st);
    do_op(F_DIV, 32'hFFFF_FFF9, 32'h0000_0002, st);
    do_op(F_DIVU, 32'h0000_0007, 32'h0000_0000, st);

    // MULT, ADD while busy, then MFLO issued every cycle.
    do_op(F_MULT, 32'h0001_2345, 32'hFFFF_0F00, st);
    ALUOp = ALUOP_ADD;
    Funct = F_MFLO;
    issue = 1'b1;
    #1;
    check("add_while_busy stall", W2'(stall), '0);
    check("add_while_busy busy", W2'(busy), W2'(1));
    do_op(F_MFLO, '0, '0, st);
    check("mflo stall_cycles", W2'(st), W2'(W + 1));

    // MTHI/MFHI and MIN / -1.
    do_op(F_MTHI, 32'h1234_5678, '0, st);
    do_op(F_MFHI, '0, '0, st);
    do_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, st);
    do_op(F_MFLO, '0, '0, st);

    // Reset 10 cycles into a DIV with an MFLO waiting behind it.
    do_op(F_DIV, 32'h7654_3210, 32'h0000_0123, st);
    repeat (9) @(posedge clk);
    #1;
    ALUOp = ALUOP_RFORMAT;
    Funct = F_MFLO;
    issue = 1'b1;
    reset = 1'b1;
    #1;
    check("pre_reset stall", W2'(stall), W2'(1));
    @(posedge clk);
    #1;
    check("post_reset busy", W2'(busy), '0);
    check("post_reset stall", W2'(stall), '0);
    check("post_reset hi_lo", {hi, lo}, '0);
    issue = 1'b0;
    reset = 1'b0;
    res_q.delete();
    hi_m = '0;
    lo_m = '0;
    do_op(F_MULTU, 32'd3, 32'd5, st);
    do_op(F_MFHI, '0, '0, st);

    // Randomized mix with idle gaps and non-HI/LO traffic.
    for (int n = 0; n < 48; n++) begin
      logic [5:0] f;
      case ($urandom_range(0, 7))
        0: f = F_MULT;
        1: f = F_MULTU;
        2: f = F_DIV;
        3: f = F_DIVU;
        4: f = F_MTHI;
        5: f = F_MTLO;
        6: f = F_MFHI;
        default: f = F_MFLO;
      endcase
      do_op(f, pick(), pick(), st);
      repeat ($urandom_range(0, 2)) begin
        ALUOp = ALUOP_ADD;
        issue = 1'b1;
        #1;
        check("rand nonhilo stall", W2'(stall), '0);
        @(posedge clk);
        #1;
        issue = 1'b0;
      end
    end

    for (int i = 0; i < 100 && busy; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("pending results", W2'(res_q.size()), '0);
    check("pending reads", W2'(mf_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
